// File: rtl/stack_cpu_pkg.sv
// Encodings shared by the stack CPU decoder/controller and the operand stack.
// Holds the stack-pointer update modes, write-source selects, fault codes and RUN/FAULT states.
package stack_cpu_pkg;

  typedef enum logic [1:0] {
    SUM_HOLD = 2'b00,
    SUM_INC  = 2'b01,
    SUM_DEC2 = 2'b10,
    SUM_DEC1 = 2'b11
  } stack_update_mode_e;

  typedef enum logic [1:0] {
    SWS_NONE = 2'b00,
    SWS_ALU  = 2'b01,
    SWS_DMEM = 2'b10,
    SWS_PC   = 2'b11
  } stack_write_src_e;

  typedef enum logic [1:0] {
    FC_NONE      = 2'b00,
    FC_UNDERFLOW = 2'b01,
    FC_OVERFLOW  = 2'b10,
    FC_ILLEGAL   = 2'b11
  } fault_code_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } stack_state_e;

  // Minimum occupancy an operation requires before the edge: the entries it
  // consumes, or the entry it overwrites in place.
  function automatic logic [1:0] stack_need(input logic [1:0] mode, input logic wr);
    case (mode)
      SUM_DEC2: return 2'd2;
      SUM_DEC1: return wr ? 2'd2 : 2'd1;
      SUM_HOLD: return wr ? 2'd1 : 2'd0;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_ptr_ctrl.sv
// Stack-pointer controller: next-pointer arithmetic, legality check and the
// RUN/FAULT state machine with its latched fault code.
module stack_ptr_ctrl
  import stack_cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SPW   = $clog2(DEPTH + 1),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic [1:0]     mode,
  input  logic           wr_req,
  input  logic           fault_clr,
  output logic [SPW-1:0] sp,
  output logic [AW-1:0]  wr_idx,
  output logic           wr_commit,
  output logic           fault,
  output logic [1:0]     fault_code
);

  stack_state_e   state;
  logic [SPW-1:0] new_sp;
  logic [SPW-1:0] need;
  logic           underflow;
  logic           overflow;
  logic           legal;

  always_comb begin
    need = SPW'(stack_need(mode, wr_req));
    case (mode)
      SUM_INC:  new_sp = sp + SPW'(1);
      SUM_DEC2: new_sp = sp - SPW'(2);
      SUM_DEC1: new_sp = sp - SPW'(1);
      default:  new_sp = sp;
    endcase
  end

  // A wrapped new_sp after an underflow must not also raise overflow.
  assign underflow = (sp < need);
  assign overflow  = !underflow && (new_sp > SPW'(DEPTH));
  assign legal     = !underflow && !overflow;

  // new_sp == DEPTH maps to the last slot through the low-bit wrap of -1.
  assign wr_idx    = new_sp[AW-1:0] - AW'(1);
  assign wr_commit = en && (state == ST_RUN) && legal && wr_req;
  assign fault     = (state == ST_FAULT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      sp         <= '0;
      fault_code <= FC_NONE;
    end else begin
      case (state)
        ST_RUN: begin
          if (en) begin
            if (underflow) begin
              state      <= ST_FAULT;
              fault_code <= FC_UNDERFLOW;
            end else if (overflow) begin
              state      <= ST_FAULT;
              fault_code <= FC_OVERFLOW;
            end else begin
              sp <= new_sp;
            end
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state      <= ST_RUN;
            fault_code <= FC_NONE;
          end
        end
        default: begin
          state      <= ST_RUN;
          fault_code <= FC_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/stack_unit.sv
// Operand stack for the single-cycle stack CPU: storage array, write-source
// mux and combinational top/second read ports; pointer/fault logic lives in stack_ptr_ctrl.
module stack_unit
  import stack_cpu_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int SPW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       StackUpdateMode,
  input  logic [1:0]       StackWriteSrc,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic [WIDTH-1:0] pc_temp,
  input  logic             fault_clr,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [SPW-1:0]   sp,
  output logic             empty,
  output logic             full,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    second_idx;
  logic             wr_req;
  logic             wr_commit;

  assign wr_req = (StackWriteSrc != SWS_NONE);

  stack_ptr_ctrl #(
    .DEPTH (DEPTH),
    .SPW   (SPW),
    .AW    (AW)
  ) u_ctrl (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .mode       (StackUpdateMode),
    .wr_req     (wr_req),
    .fault_clr  (fault_clr),
    .sp         (sp),
    .wr_idx     (wr_idx),
    .wr_commit  (wr_commit),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always_comb begin
    case (StackWriteSrc)
      SWS_ALU:  wr_data = alu_result;
      SWS_DMEM: wr_data = dmem_rdata;
      SWS_PC:   wr_data = pc_temp;
      default:  wr_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_commit) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Reads come straight from the array; a write shows up after its edge.
  assign top_idx    = sp[AW-1:0] - AW'(1);
  assign second_idx = sp[AW-1:0] - AW'(2);
  assign top        = (sp >= SPW'(1)) ? mem[top_idx]    : '0;
  assign second     = (sp >= SPW'(2)) ? mem[second_idx] : '0;
  assign empty      = (sp == '0);
  assign full       = (sp == SPW'(DEPTH));

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed operation sequence, an array-based
// reference model compared on every falling edge, plus literal spot checks.
module tb_stack_unit;

  localparam int W = 32;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    StackUpdateMode = 2'b00;
  logic [1:0]    StackWriteSrc = 2'b00;
  logic [W-1:0]  alu_result = '0;
  logic [W-1:0]  dmem_rdata = '0;
  logic [W-1:0]  pc_temp = '0;
  logic          fault_clr = 1'b0;
  logic [W-1:0]  top;
  logic [W-1:0]  second;
  logic [4:0]    sp;
  logic          empty;
  logic          full;
  logic          fault;
  logic [1:0]    fault_code;

  stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .en              (en),
    .StackUpdateMode (StackUpdateMode),
    .StackWriteSrc   (StackWriteSrc),
    .alu_result      (alu_result),
    .dmem_rdata      (dmem_rdata),
    .pc_temp         (pc_temp),
    .fault_clr       (fault_clr),
    .top             (top),
    .second          (second),
    .sp              (sp),
    .empty           (empty),
    .full            (full),
    .fault           (fault),
    .fault_code      (fault_code)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b0;

  // Reference model: plain occupancy count plus an array of entries.
  int          m_sp;
  logic [W-1:0] m_mem [D];
  bit          m_fault;
  int          m_code;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_top();
    return (m_sp >= 1) ? m_mem[m_sp-1] : '0;
  endfunction

  function automatic logic [W-1:0] m_second();
    return (m_sp >= 2) ? m_mem[m_sp-2] : '0;
  endfunction

  task automatic model_reset();
    m_sp = 0;
    m_fault = 0;
    m_code = 0;
    for (int i = 0; i < D; i++) m_mem[i] = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("top",        top,              m_top());
      cmp("second",     second,           m_second());
      cmp("sp",         32'(sp),          32'(m_sp));
      cmp("empty",      32'(empty),       32'(m_sp == 0));
      cmp("full",       32'(full),        32'(m_sp == D));
      cmp("fault",      32'(fault),       32'(m_fault));
      cmp("fault_code", 32'(fault_code),  32'(m_code));
    end
  end

  // Drive one cycle; unselected sources carry decoy values so a wrong mux shows up.
  task automatic step(input bit e, input logic [1:0] m, input logic [1:0] s,
                      input logic [W-1:0] d, input bit c);
    int   nsp, ncode, need, delta, widx;
    bit   nfault, wr, do_wr;
    en              = e;
    StackUpdateMode = m;
    StackWriteSrc   = s;
    fault_clr       = c;
    alu_result      = (s == 2'b01) ? d : 32'hA1A1_0001;
    dmem_rdata      = (s == 2'b10) ? d : 32'hD2D2_0002;
    pc_temp         = (s == 2'b11) ? d : 32'hC3C3_0003;
    nsp = m_sp; nfault = m_fault; ncode = m_code; do_wr = 0; widx = 0;
    wr = (s != 2'b00);
    if (m_fault) begin
      if (c) begin nfault = 0; ncode = 0; end
    end else if (e) begin
      delta = (m == 2'b01) ? 1 : (m == 2'b10) ? -2 : (m == 2'b11) ? -1 : 0;
      need  = (m == 2'b10) ? 2 : (m == 2'b11) ? (wr ? 2 : 1) : (m == 2'b00 && wr) ? 1 : 0;
      if (m_sp < need) begin
        nfault = 1; ncode = 1;
      end else if (m_sp + delta > D) begin
        nfault = 1; ncode = 2;
      end else begin
        nsp = m_sp + delta;
        if (wr) begin do_wr = 1; widx = nsp - 1; end
      end
    end
    @(posedge clk);
    #1;
    m_sp = nsp; m_fault = nfault; m_code = ncode;
    if (do_wr) m_mem[widx] = d;
  endtask

  initial begin
    model_reset();
    chk_en = 1'b1;
    #12 reset_n = 1'b1;
    @(posedge clk); #1;
    cmp("reset_sp",    32'(sp),    32'd0);
    cmp("reset_top",   top,        32'd0);
    cmp("reset_empty", 32'(empty), 32'd1);
    cmp("reset_full",  32'(full),  32'd0);
    cmp("reset_fault", 32'(fault), 32'd0);

    // push_pc twice
    step(1, 2'b01, 2'b11, 32'd5, 0);
    step(1, 2'b01, 2'b11, 32'd9, 0);
    cmp("pushpc_sp",     32'(sp),    32'd2);
    cmp("pushpc_top",    top,        32'd9);
    cmp("pushpc_second", second,     32'd5);
    cmp("pushpc_empty",  32'(empty), 32'd0);

    // binary op replaces second
    step(1, 2'b11, 2'b01, 32'd14, 0);
    cmp("binop_sp",     32'(sp), 32'd1);
    cmp("binop_top",    top,     32'd14);
    cmp("binop_second", second,  32'd0);

    // unary op in place, then branch underflow
    step(1, 2'b00, 2'b01, 32'hFFFF_FFF1, 0);
    cmp("unary_top", top, 32'hFFFF_FFF1);
    step(1, 2'b10, 2'b00, 32'd0, 0);
    cmp("br_fault", 32'(fault),      32'd1);
    cmp("br_code",  32'(fault_code), 32'd1);
    cmp("br_sp",    32'(sp),         32'd1);
    step(0, 2'b00, 2'b00, 32'd0, 1);
    cmp("clr1_fault", 32'(fault), 32'd0);

    // fill to DEPTH, then overflow
    for (int i = 0; i < 15; i++) step(1, 2'b01, 2'b01, 32'(100 + i), 0);
    cmp("fill_full", 32'(full), 32'd1);
    cmp("fill_top",  top,       32'd114);
    step(1, 2'b01, 2'b11, 32'h77, 0);
    cmp("ovf_code", 32'(fault_code), 32'd2);
    cmp("ovf_sp",   32'(sp),         32'd16);
    cmp("ovf_top",  top,             32'd114);

    // ops ignored while faulted, including the one alongside fault_clr
    for (int i = 0; i < 3; i++) step(1, 2'b11, 2'b01, 32'hBAD0 + 32'(i), 0);
    step(1, 2'b11, 2'b01, 32'hBADF, 1);
    cmp("clr2_fault", 32'(fault), 32'd0);
    cmp("clr2_sp",    32'(sp),    32'd16);
    cmp("clr2_top",   top,        32'd114);

    // mode 10 with dmem write, then pop down
    step(1, 2'b10, 2'b10, 32'hABCD, 0);
    cmp("dec2w_top",    top,    32'hABCD);
    cmp("dec2w_second", second, 32'd111);
    for (int i = 0; i < 13; i++) step(1, 2'b11, 2'b00, 32'd0, 0);
    cmp("pop_top", top, 32'hFFFF_FFF1);

    // mode 11 with write needs two entries
    step(1, 2'b11, 2'b01, 32'h1234, 0);
    cmp("dec1w_code", 32'(fault_code), 32'd1);
    step(0, 2'b00, 2'b00, 32'd0, 1);
    step(1, 2'b11, 2'b00, 32'd0, 0);
    cmp("drain_empty", 32'(empty), 32'd1);

    // bubble with an otherwise illegal mode
    step(0, 2'b10, 2'b01, 32'h55, 0);
    cmp("bubble_sp",    32'(sp),    32'd0);
    cmp("bubble_fault", 32'(fault), 32'd0);
    step(1, 2'b00, 2'b01, 32'h66, 0);
    cmp("unary_empty_code", 32'(fault_code), 32'd1);
    step(0, 2'b00, 2'b00, 32'd0, 1);

    // stale push exposes the old entry
    step(1, 2'b01, 2'b00, 32'd0, 0);
    cmp("stale_top", top, 32'hFFFF_FFF1);
    step(1, 2'b01, 2'b11, 32'd7, 0);
    step(1, 2'b01, 2'b11, 32'd8, 0);
    cmp("pre_rst_sp", 32'(sp), 32'd3);

    // asynchronous reset between edges
    reset_n = 1'b0;
    #1;
    cmp("async_sp",    32'(sp),    32'd0);
    cmp("async_top",   top,        32'd0);
    cmp("async_fault", 32'(fault), 32'd0);
    model_reset();
    #2 reset_n = 1'b1;
    step(1, 2'b01, 2'b11, 32'h33, 0);
    cmp("post_rst_top", top, 32'h33);
    step(0, 2'b00, 2'b00, 32'd0, 0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
